// File: rtl/wb_narrow_ram.sv
// Wishbone classic line responder backed by a narrow word array.
// Serialises each wide line access into one narrow word per cycle.
module wb_narrow_ram #(
  parameter int DATA_W   = 128,
  parameter int ADDR_W   = 16,
  parameter int DEPTH    = 16,
  parameter int NARROW_W = 32,
  parameter int WAIT     = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cyc_i,
  input  logic                  stb_i,
  input  logic                  we_i,
  input  logic [ADDR_W-1:0]     adr_i,
  input  logic [DATA_W/8-1:0]   sel_i,
  input  logic [DATA_W-1:0]     dat_i,
  output logic [DATA_W-1:0]     dat_o,
  output logic                  ack_o,
  output logic                  err_o
);

  localparam int BEATS = DATA_W / NARROW_W;
  localparam int NB    = NARROW_W / 8;
  localparam int OFF   = $clog2(DATA_W / 8);
  localparam int LAW   = ADDR_W - OFF;
  localparam int LIW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int NW    = DEPTH * BEATS;
  localparam int WIW   = (NW > 1) ? $clog2(NW) : 1;
  localparam int WW    = (WAIT > 1) ? $clog2(WAIT) : 1;

  typedef enum logic [2:0] {
    IDLE, BEAT, HOLD, ACK, ERR
  } state_t;

  state_t state, state_n;

  logic [NARROW_W-1:0] mem [NW];

  logic [LIW-1:0]      line_q;
  logic                we_q;
  logic [DATA_W/8-1:0] sel_q;
  logic [DATA_W-1:0]   dat_q;
  logic [CW-1:0]       cnt;
  logic [WW-1:0]       wcnt;

  logic           req;
  logic           in_range;
  logic           last_beat;
  logic           last_wait;
  logic           beat_go;
  logic           ack_n;
  logic           err_n;
  logic [LAW-1:0] line_in;
  logic [WIW-1:0] widx;
  logic           unused_adr;

  assign req       = cyc_i & stb_i;
  assign line_in   = adr_i[ADDR_W-1:OFF];
  assign in_range  = line_in < LAW'(DEPTH);
  assign last_beat = cnt == CW'(BEATS - 1);
  assign last_wait = wcnt == WW'(WAIT - 1);
  assign beat_go   = (state == BEAT) && cyc_i;
  assign widx      = WIW'(line_q) * WIW'(BEATS)
                   + WIW'(cnt);
  assign unused_adr = ^adr_i[OFF-1:0];

  // Next state and next registered ack/err; abort wins over a beat.
  always_comb begin
    state_n = state;
    ack_n   = 1'b0;
    err_n   = 1'b0;
    unique case (state)
      IDLE: begin
        if (req) begin
          state_n = in_range ? BEAT : ERR;
        end
      end
      BEAT: begin
        if (!cyc_i) begin
          state_n = IDLE;
        end else if (last_beat) begin
          if (WAIT > 0) begin
            state_n = HOLD;
          end else begin
            state_n = ACK;
            ack_n   = 1'b1;
          end
        end
      end
      HOLD: begin
        if (!cyc_i) begin
          state_n = IDLE;
        end else if (last_wait) begin
          state_n = ACK;
          ack_n   = 1'b1;
        end
      end
      ACK: begin
        state_n = IDLE;
      end
      ERR: begin
        if (cnt == '0) begin
          err_n = 1'b1;
        end else begin
          state_n = IDLE;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // State, responses, counters, request latch and read-beat loading.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ack_o <= 1'b0;
      err_o <= 1'b0;
      dat_o <= '0;
      cnt   <= '0;
      wcnt  <= '0;
    end else begin
      state <= state_n;
      ack_o <= ack_n;
      err_o <= err_n;
      unique case (state)
        IDLE: begin
          cnt  <= '0;
          wcnt <= '0;
          if (req && in_range) begin
            line_q <= LIW'(line_in);
            we_q   <= we_i;
            sel_q  <= sel_i;
            dat_q  <= dat_i;
          end
        end
        BEAT: begin
          if (cyc_i && !last_beat) begin
            cnt <= cnt + 1'b1;
          end else begin
            cnt <= '0;
          end
          if (beat_go && !we_q) begin
            dat_o[int'(cnt)*NARROW_W +: NARROW_W]
              <= mem[widx];
          end
        end
        HOLD: begin
          if (cyc_i && !last_wait) begin
            wcnt <= wcnt + 1'b1;
          end else begin
            wcnt <= '0;
          end
        end
        ERR: begin
          cnt <= (cnt == '0) ? CW'(1) : '0;
        end
        default: begin
          cnt  <= '0;
          wcnt <= '0;
        end
      endcase
    end
  end

  // Byte-masked write of the current word during a write beat.
  always_ff @(posedge clk) begin
    if (!rst && beat_go && we_q) begin
      for (int b = 0; b < NB; b++) begin
        if (sel_q[int'(cnt)*NB + b]) begin
          mem[widx][8*b +: 8] <=
            dat_q[int'(cnt)*NARROW_W + 8*b +: 8];
        end
      end
    end
  end

endmodule
